// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-programmable word data-memory responder with byte strobes
// Define DMEM_RESPONDER_STATS_EN to add saturating rd_count/wr_count outputs.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_RESPONDER_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             acc_err;
  logic             wr_en;
  logic [31:0]      rdata_d;

  // The 33-bit compare keeps addresses near 0xFFFFFFFF from aliasing into the array.
  assign idx     = addr_q[IDX_W+1:2];
  assign acc_err = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= LIMIT);
  assign wr_en   = !rst && (state_q == EXEC) && write_q && !acc_err;
  assign rdata_d = (write_q || acc_err) ? 32'h0 : mem_q[idx];

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

`ifdef DMEM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
`ifdef DMEM_RESPONDER_STATS_EN
      rd_cnt_q <= 16'h0;
      wr_cnt_q <= 16'h0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q <= EXEC;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= EXEC;
        end
        EXEC: begin
          valid_q <= 1'b1;
          err_q   <= acc_err;
          rdata_q <= rdata_d;
          state_q <= RESP;
`ifdef DMEM_RESPONDER_STATS_EN
          if (!acc_err) begin
            if (write_q) begin
              if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
              if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder against a word-array model
// Build with DMEM_RESPONDER_STATS_EN to also check rd_count/wr_count.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_RESPONDER_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model [DEPTH];
  int          exp_rd = 0;
  int          exp_wr = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_RESPONDER_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_err(input logic [31:0] a);
    return (a % 4 != 0) || ({32'd0, a} >= 64'(DEPTH) * 4);
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, req_ready, 1);
    check_eq({tag, "_valid"}, rsp_valid, 0);
    check_eq({tag, "_rdata"}, rsp_rdata, 0);
    check_eq({tag, "_err"}, rsp_err, 0);
  endtask

  // Called 1 time unit after a rising edge with the responder idle.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int hold);
    int          edges;
    logic        e;
    logic [31:0] er;
    e  = is_err(a);
    er = (w || e) ? 32'h0 : model[a / 4];
    check_eq("ready_before", req_ready, 1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    @(posedge clk); #1;
    req_valid = 0; req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    edges = 0;
    while (!rsp_valid && edges < 40) begin
      check_eq("ready_busy", req_ready, 0);
      rsp_ready = 1'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    check_eq("latency", edges, LAT);
    check_eq("rsp_err", rsp_err, e);
    check_eq("rsp_rdata", rsp_rdata, er);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 0;
      @(posedge clk); #1;
      check_eq("hold_valid", rsp_valid, 1);
      check_eq("hold_rdata", rsp_rdata, er);
      check_eq("hold_err", rsp_err, e);
      check_eq("hold_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check_idle("after_hs");
    if (!e) begin
      if (w) begin
        for (int l = 0; l < 4; l++)
          if (s[l]) model[a / 4][8*l +: 8] = d[8*l +: 8];
        exp_wr++;
      end else begin
        exp_rd++;
      end
    end
  endtask

  // Starts a store, then asserts reset on the edge that is 'pos' edges after acceptance.
  task automatic reset_mid(input logic [31:0] a, input logic [31:0] d, input int pos);
    req_valid = 1; req_write = 1; req_addr = a; req_wdata = d; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 0;
    for (int i = 1; i < pos; i++) begin
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_rd = 0; exp_wr = 0;
    check_idle("rst_mid");
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_quiet", rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 0;

    for (int i = 0; i < DEPTH; i++) xact(1, 32'(i * 4), $urandom, 4'hF, 0);
    xact(1, 32'h20, 32'h0, 4'hF, 0);

    xact(1, 32'h10, 32'h12345678, 4'hF, 0);
    xact(0, 32'h10, 32'h0, 4'h0, 0);
    check_eq("raw_full", model[4], 32'h12345678);
    xact(1, 32'h10, 32'hAABBCCDD, 4'b0101, 0);
    xact(0, 32'h10, 32'h0, 4'h0, 0);
    xact(1, 32'h14, 32'hFFFFFFFF, 4'h0, 1);
    xact(0, 32'h14, 32'h0, 4'h0, 0);
    xact(0, 32'h12, 32'h0, 4'h0, 0);
    xact(1, 32'h400, 32'hCAFEF00D, 4'hF, 0);
    xact(1, 32'hFFFFFFFC, 32'hCAFEF00D, 4'hF, 0);
    xact(0, 32'h3FC, 32'h0, 4'h0, 0);
    xact(0, 32'h10, 32'h0, 4'h0, 5);

    reset_mid(32'h20, 32'hDEADBEEF, 1);
    xact(0, 32'h20, 32'h0, 4'h0, 0);
    reset_mid(32'h24, 32'h55AA55AA, 2);
    xact(0, 32'h24, 32'h0, 4'h0, 0);

    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_rd = 0; exp_wr = 0;
    xact(0, 32'h0, 0, 0, 0);
    xact(0, 32'h4, 0, 0, 0);
    xact(0, 32'h8, 0, 0, 0);
    xact(1, 32'h30, $urandom, 4'hF, 0);
    xact(1, 32'h34, $urandom, 4'h3, 0);
    xact(0, 32'h31, 0, 0, 0);
`ifdef DMEM_RESPONDER_STATS_EN
    check_eq("rd_count_dir", 32'(rd_count), 3);
    check_eq("wr_count_dir", 32'(wr_count), 2);
`endif

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom % 10);
      if (r < 7)       a = ($urandom % DEPTH) * 4;
      else if (r == 7) a = ($urandom % DEPTH) * 4 + 1 + ($urandom % 3);
      else if (r == 8) a = DEPTH * 4 + ($urandom % 1000) * 4;
      else             a = 32'hFFFFFFFC - ($urandom % 4) * 4;
      xact(1'($urandom), a, $urandom, 4'($urandom), int'($urandom % 4));
    end
`ifdef DMEM_RESPONDER_STATS_EN
    check_eq("rd_count_rand", 32'(rd_count), exp_rd);
    check_eq("wr_count_rand", 32'(wr_count), exp_wr);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory load/store interface.
- Accepts one request at a time over a valid/ready handshake.
- Performs a word access with byte-lane write strobes after a programmable latency.
- Returns the result over a valid/ready response channel.
- Replaces the zero-latency combinational data memory, so the core and bench can exercise wait-state behaviour.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the storage array; power of two, minimum 4.
- LATENCY, 2, cycles from request acceptance edge to the edge that raises rsp_valid; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte-lane enables; bit i covers wdata[8i+7:8i]; ignored for loads.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0, all request capture registers=0. Storage array contents are not reset. Reset wins over any in-flight transaction; the pending access is dropped and no write occurs.
- State IDLE: req_ready=1.
  - On an edge with req_valid=1, capture write, addr, wdata and wstrb.
  - If LATENCY=1, go to EXEC; otherwise go to WAIT with counter=LATENCY-1.
- State WAIT: req_ready=0. Counter decrements each edge; at counter=1 move to EXEC. Input changes during WAIT are ignored (inputs are captured).
- State EXEC (internal, one edge):
  - Word index = addr[31:2].
  - err = (addr[1:0]!=0) or (addr >= DEPTH_WORDS*4).
  - On a store with no error: write each lane whose wstrb bit is set. wstrb=0 is a legal no-op.
  - On a load with no error: rsp_rdata = mem[index].
  - On an error: no write, rsp_rdata=0, rsp_err=1.
  - Set rsp_valid=1 and go to RESP.
- Timing: a request accepted at edge N gives rsp_valid=1 after edge N+LATENCY.
- State RESP: rsp_valid=1 and req_ready=0. rsp_rdata and rsp_err stay stable until handshake. On an edge with rsp_ready=1, clear rsp_valid, rsp_rdata and rsp_err, and go to IDLE.
- Throughput: next request acceptance is no earlier than the edge after the response handshake. One outstanding transaction maximum; peak throughput is one access per LATENCY+2 cycles.
- Read-after-write: a load issued after a store's response handshake returns the stored bytes merged with the previous contents of unstrobed lanes.
- Address arithmetic is unsigned 32-bit; no wrap-around into the array. Addresses at or beyond DEPTH_WORDS*4 always error, including 0xFFFFFFFC.
- req_valid while req_ready=0 has no effect; the initiator must hold the request until accepted.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro DMEM_RESPONDER_STATS_EN.
- When defined, two extra outputs are added:
  - rd_count, output, 16 bits: count of completed non-error loads.
  - wr_count, output, 16 bits: count of completed non-error stores.
- Both counters increment at the EXEC edge, saturate at 0xFFFF, and reset to 0 on rst. Error accesses are not counted.
- When not defined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Store word 0x12345678 at 0x10 with wstrb=4'hF. Expect req_ready low for 3 cycles, rsp_valid high 2 edges after acceptance, rsp_err=0, rsp_rdata=0. A following load of 0x10 returns 0x12345678.
- Store 0xAABBCCDD at 0x10 with wstrb=4'b0101, then load 0x10 -> 0x12BB56DD.
- Load 0x12 (misaligned) -> rsp_err=1, rsp_rdata=0. Store 0x400 (DEPTH_WORDS=256) -> rsp_err=1. A later load of 0x3FC shows no corruption.
- Hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0. On handshake, req_ready returns to 1 on the next cycle.
- Assert rst for one edge while in WAIT on a store to 0x20 (old data 0x0) -> outputs return to reset values next cycle. A following load of 0x20 returns 0x0.
- With DMEM_RESPONDER_STATS_EN: 3 good loads, 2 good stores and 1 misaligned load -> rd_count=3, wr_count=2.
